// File: rtl/gpcfg_pkg.sv
// Shared types and constants for the gpcfg AHB-Lite front-end: FSM states, AHB encodings,
// and the lane decoder that gives byte enables and alignment errors for the bank.
package gpcfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef struct packed {
    logic [3:0] byte_en;
    logic       misaligned;
  } lane_dec_t;

  // Sizes above a word cannot be expressed on a 32-bit bank, so they are treated as misaligned.
  function automatic lane_dec_t lane_decode(input logic [2:0] hsize, input logic [1:0] addr_lo);
    lane_dec_t d;
    d.byte_en    = 4'b0000;
    d.misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: d.byte_en = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        d.byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        d.misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        d.byte_en    = 4'b1111;
        d.misaligned = (addr_lo != 2'b00);
      end
      default: d.misaligned = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gpcfg_ahb_if.sv
// AHB-Lite slave-port signal bundle between the interconnect (master side) and gpcfg_ahb_ctrl.
interface gpcfg_ahb_if;
  // Handshake: an address phase is taken only when hsel & htrans[1] & hready are all high at a
  // rising edge; a data phase completes at the first rising edge where hreadyout is high.
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/gpcfg_addr_chk.sv
// Combinational address checker: byte lanes plus a single error flag covering bad size,
// misalignment and offsets beyond the mapped register window.
module gpcfg_addr_chk
  import gpcfg_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [15:0] offset,
  input  logic [2:0]  hsize,
  output logic [3:0]  byte_en,
  output logic        err
);

  localparam logic [16:0] MAP_LIMIT = 17'(NUM_REGS * 4);

  lane_dec_t dec;

  always_comb begin
    dec     = lane_decode(hsize, offset[1:0]);
    byte_en = dec.byte_en;
    err     = dec.misaligned | ({1'b0, offset} >= MAP_LIMIT);
  end

endmodule

// File: rtl/gpcfg_ahb_ctrl.sv
// AHB-Lite slave front-end for the gpcfg register bank: turns address/data phases into
// single-cycle write strobes, wait-stated read strobes and two-cycle ERROR responses.
module gpcfg_ahb_ctrl
  import gpcfg_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int RD_WAIT_CYCLES = 1
) (
  input  logic              hclk,
  input  logic              hreset,
  gpcfg_ahb_if.slave        ahb,
  output logic              cfg_wr_en,
  output logic [3:0]        cfg_byte_en,
  output logic [31:0]       cfg_wr_addr,
  output logic [31:0]       cfg_wdata,
  output logic              cfg_rd_en,
  output logic [31:0]       cfg_rd_addr,
  input  logic [31:0]       cfg_rdata,
  output state_t            dbg_state
);

  localparam int CNT_W = (RD_WAIT_CYCLES > 1) ? $clog2(RD_WAIT_CYCLES) : 1;

  state_t             state, state_nxt, target;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        hrdata_q;
  logic [3:0]         chk_be;
  logic               chk_err;
  logic               bus_open;
  logic               accept;
  logic               rd_done;
  logic               ready_c;
  logic               resp_c;

  gpcfg_addr_chk #(.NUM_REGS(NUM_REGS)) u_addr_chk (
    .offset  (ahb.haddr[15:0]),
    .hsize   (ahb.hsize),
    .byte_en (chk_be),
    .err     (chk_err)
  );

  // A new address phase can only be taken in states that present hreadyout=1.
  assign bus_open = (state == ST_IDLE) || (state == ST_WRITE) ||
                    (state == ST_RDATA) || (state == ST_ERR2);
  assign accept   = ahb.hsel & ahb.htrans[1] & ahb.hready & bus_open;
  assign rd_done  = (cnt == CNT_W'(RD_WAIT_CYCLES - 1));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= ahb.haddr;
        be_q   <= chk_be;
      end
      if (state == ST_READ) begin
        if (rd_done) begin
          cnt      <= '0;
          hrdata_q <= cfg_rdata;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ready_c     = 1'b1;
    resp_c      = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_byte_en = 4'b0000;
    cfg_wdata   = 32'h0;
    cfg_rd_en   = 1'b0;
    target      = chk_err ? ST_ERR1 : (ahb.hwrite ? ST_WRITE : ST_READ);
    case (state)
      ST_IDLE: if (accept) state_nxt = target;
      ST_WRITE: begin
        cfg_wr_en   = 1'b1;
        cfg_byte_en = be_q;
        cfg_wdata   = ahb.hwdata;
        state_nxt   = accept ? target : ST_IDLE;
      end
      ST_READ: begin
        ready_c   = 1'b0;
        cfg_rd_en = 1'b1;
        if (rd_done) state_nxt = ST_RDATA;
      end
      ST_RDATA: state_nxt = accept ? target : ST_IDLE;
      ST_ERR1: begin
        ready_c   = 1'b0;
        resp_c    = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        resp_c    = 1'b1;
        state_nxt = accept ? target : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ahb.hreadyout = ready_c;
  assign ahb.hresp     = resp_c;
  assign ahb.hrdata    = hrdata_q;
  assign cfg_wr_addr   = addr_q;
  assign cfg_rd_addr   = addr_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_gpcfg_ahb_ctrl.sv
// Bench for gpcfg_ahb_ctrl: directed AHB transfers, a small register-bank model on the cfg side,
// and a negedge monitor that checks responses and write strobes against expected queues.
module tb_gpcfg_ahb_ctrl;
  import gpcfg_pkg::*;

  logic        hclk;
  logic        hreset;
  logic        stall;
  logic        cfg_wr_en;
  logic [3:0]  cfg_byte_en;
  logic [31:0] cfg_wr_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_rd_en;
  logic [31:0] cfg_rd_addr;
  logic [31:0] cfg_rdata;
  state_t      dbg_state;

  gpcfg_ahb_if ahb ();

  gpcfg_ahb_ctrl #(.NUM_REGS(16), .RD_WAIT_CYCLES(1)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .ahb         (ahb.slave),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_byte_en (cfg_byte_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rd_en   (cfg_rd_en),
    .cfg_rd_addr (cfg_rd_addr),
    .cfg_rdata   (cfg_rdata),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / bus-level ready ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  assign ahb.hready = ahb.hreadyout & ~stall;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register bank model ----------------
  logic [31:0] bank [16];

  always @(posedge hclk) begin
    if (!hreset && cfg_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (cfg_byte_en[b]) bank[cfg_wr_addr[5:2]][8*b +: 8] <= cfg_wdata[8*b +: 8];
    end
  end

  assign cfg_rdata = cfg_rd_en ? bank[cfg_rd_addr[5:2]] : 32'h0;

  // ---------------- scoreboard ----------------
  // Response entry: {is_read, resp, waits[3:0], rdata[31:0]}; write entry: {addr, be, data}.
  logic [37:0] exp_q[$];
  logic [67:0] wr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        active = 1'b0;
  logic        cur_err = 1'b0;
  int          waits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] mk_resp(input logic is_rd, input logic rsp,
                                          input logic [3:0] w, input logic [31:0] d);
    return {is_rd, rsp, w, d};
  endfunction

  always @(negedge hclk) begin
    logic [37:0] e;
    logic [67:0] w;
    if (hreset) begin
      active = 1'b0;
    end else begin
      if (cfg_wr_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_wr_strobe", 64'(cfg_wr_en), 64'(1'b0));
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 64'(cfg_wr_addr), 64'(w[67:36]));
          check("wr_be",   64'(cfg_byte_en), 64'(w[35:32]));
          check("wr_data", 64'(cfg_wdata),   64'(w[31:0]));
        end
      end
      if (active) begin
        if (!ahb.hreadyout) begin
          waits++;
          if (cur_err) begin
            check("err1_hresp", 64'(ahb.hresp), 64'(1'b1));
            check("err1_rd_en", 64'(cfg_rd_en), 64'(1'b0));
          end
        end else begin
          active = 1'b0;
          e = exp_q.pop_front();
          check("resp",  64'(ahb.hresp), 64'(e[36]));
          check("waits", 64'(waits),     64'(e[35:32]));
          if (e[37] && !e[36]) check("rdata", 64'(ahb.hrdata), 64'(e[31:0]));
        end
      end
      if (ahb.hsel && ahb.htrans[1] && ahb.hready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 64'(1), 64'(0));
        end else begin
          active  = 1'b1;
          waits   = 0;
          cur_err = exp_q[0][36];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata);
    logic ok;
    int   guard;
    guard = 0;
    ahb.hsel   = 1'b1;
    ahb.htrans = HTRANS_NONSEQ;
    ahb.hwrite = wr;
    ahb.haddr  = addr;
    ahb.hsize  = size;
    forever begin
      @(negedge hclk);
      ok = ahb.hready;
      @(posedge hclk);
      if (ok) break;
      guard++;
      if (guard > 20) begin
        check("accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    #1;
    ahb.hwdata = wdata;
    ahb.hsel   = 1'b0;
    ahb.htrans = HTRANS_IDLE;
  endtask

  task automatic bus_drain();
    for (int i = 0; i < 20; i++) begin
      @(posedge hclk);
      #1;
      if (!active) return;
    end
    check("drain_timeout", 64'(active), 64'(0));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data, input logic [3:0] be);
    wr_q.push_back({addr, be, data});
    exp_q.push_back(mk_resp(1'b0, 1'b0, 4'd0, 32'h0));
    addr_phase(1'b1, addr, size, data);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    exp_q.push_back(mk_resp(1'b1, 1'b0, 4'd1, data));
    addr_phase(1'b0, addr, size, 32'h0);
  endtask

  task automatic do_error(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    exp_q.push_back(mk_resp(~wr, 1'b1, 4'd1, 32'h0));
    addr_phase(wr, addr, size, 32'h0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) bank[i] = 32'h0;
    stall      = 1'b0;
    hreset     = 1'b1;
    ahb.hsel   = 1'b0;
    ahb.haddr  = 32'h0;
    ahb.htrans = HTRANS_IDLE;
    ahb.hwrite = 1'b0;
    ahb.hsize  = HSIZE_WORD;
    ahb.hwdata = 32'h0;
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;

    check("rst_hreadyout", 64'(ahb.hreadyout), 64'(1'b1));
    check("rst_hresp",     64'(ahb.hresp),     64'(1'b0));
    check("rst_hrdata",    64'(ahb.hrdata),    64'(32'h0));
    check("rst_wr_en",     64'(cfg_wr_en),     64'(1'b0));
    check("rst_rd_en",     64'(cfg_rd_en),     64'(1'b0));
    check("rst_wr_addr",   64'(cfg_wr_addr),   64'(32'h0));
    check("rst_state",     64'(dbg_state),     64'(ST_IDLE));

    // Word write then read back
    do_write(32'h4, HSIZE_WORD, 32'hDEAD_BEEF, 4'hF);
    bus_drain();
    do_read(32'h4, HSIZE_WORD, 32'hDEAD_BEEF);
    bus_drain();

    // Sub-word lanes: byte at 0x7, half at 0x6, then full-word and byte reads of the result
    do_write(32'h7, HSIZE_BYTE, 32'h1122_3344, 4'b1000);
    do_write(32'h6, HSIZE_HALF, 32'h5566_7788, 4'b1100);
    bus_drain();
    do_read(32'h4, HSIZE_WORD, 32'h5566_BEEF);
    do_read(32'h5, HSIZE_BYTE, 32'h5566_BEEF);
    bus_drain();

    // Error responses, issued back-to-back
    do_error(1'b0, 32'h2,  HSIZE_WORD);
    do_error(1'b1, 32'h40, HSIZE_WORD);
    do_error(1'b1, 32'h0,  3'd3);
    do_error(1'b0, 32'h1,  HSIZE_HALF);
    bus_drain();

    // Back-to-back write then read of the same offset
    do_write(32'h8, HSIZE_WORD, 32'hCAFE_F00D, 4'hF);
    do_read(32'h8, HSIZE_WORD, 32'hCAFE_F00D);
    bus_drain();

    // Address phase held off by another slave's stall, at the top mapped word
    stall = 1'b1;
    fork
      begin
        repeat (3) @(posedge hclk);
        #1;
        stall = 1'b0;
      end
    join_none
    do_write(32'h3C, HSIZE_WORD, 32'h0BAD_F00D, 4'hF);
    do_read(32'h3C, HSIZE_WORD, 32'h0BAD_F00D);
    bus_drain();

    // Selected but BUSY: no transfer, OKAY, zero wait
    ahb.hsel   = 1'b1;
    ahb.htrans = HTRANS_BUSY;
    ahb.hwrite = 1'b1;
    ahb.haddr  = 32'hC;
    repeat (2) begin
      @(negedge hclk);
      check("busy_hreadyout", 64'(ahb.hreadyout), 64'(1'b1));
      check("busy_hresp",     64'(ahb.hresp),     64'(1'b0));
    end
    @(posedge hclk);
    #1;
    ahb.hsel   = 1'b0;
    ahb.htrans = HTRANS_IDLE;

    // Reset during the read wait cycle aborts the read
    exp_q.push_back(mk_resp(1'b1, 1'b0, 4'd1, 32'h0));
    addr_phase(1'b0, 32'h8, HSIZE_WORD, 32'h0);
    check("pre_rst_rd_en", 64'(cfg_rd_en), 64'(1'b1));
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    void'(exp_q.pop_front());
    check("abort_hreadyout", 64'(ahb.hreadyout), 64'(1'b1));
    check("abort_hresp",     64'(ahb.hresp),     64'(1'b0));
    check("abort_hrdata",    64'(ahb.hrdata),    64'(32'h0));
    check("abort_rd_en",     64'(cfg_rd_en),     64'(1'b0));
    check("abort_state",     64'(dbg_state),     64'(ST_IDLE));
    repeat (3) @(posedge hclk);
    #1;

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("wr_q_empty",  64'(wr_q.size()),  64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
